// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, frame-buffer geometry and the RGB332 pixel layout.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int SCALE_SHIFT = 2;
  localparam int ADDR_W = 15;
  localparam int CNT_W = 10;
  function automatic int total(input int a, input int fp, input int s, input int bp);
    return a + fp + s + bp;
  endfunction
  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: h/v raster counters with raw (undelayed) sync, image-window and frame-start flags.
module vga_timing #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP = vga_pkg::V_BP,
  parameter int IMG_W = vga_pkg::IMG_W,
  parameter int IMG_H = vga_pkg::IMG_H,
  parameter int SCALE_SHIFT = vga_pkg::SCALE_SHIFT
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [vga_pkg::CNT_W-1:0]  h_o,
  output logic [vga_pkg::CNT_W-1:0]  v_o,
  output logic                       hs_o,
  output logic                       vs_o,
  output logic                       img_o,
  output logic                       fs_o,
  output logic                       h_wrap_o,
  output logic                       v_wrap_o
);
  import vga_pkg::CNT_W;
  import vga_pkg::total;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [CNT_W-1:0] h_q, v_q;
  assign h_o = h_q;
  assign v_o = v_q;
  assign h_wrap_o = h_q == H_LAST;
  assign v_wrap_o = v_q == V_LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_wrap_o ? '0 : h_q + 1'b1;
      if (h_wrap_o) v_q <= v_wrap_o ? '0 : v_q + 1'b1;
    end
  end
  always_comb begin
    hs_o = !(h_q >= HS_BEG && h_q <= HS_END);
    vs_o = !(v_q >= VS_BEG && v_q <= VS_END);
    img_o = h_q < CNT_W'(H_ACTIVE) && v_q < CNT_W'(V_ACTIVE) &&
            (h_q >> SCALE_SHIFT) < CNT_W'(IMG_W) && (v_q >> SCALE_SHIFT) < CNT_W'(IMG_H);
    fs_o = h_q == '0 && v_q == '0;
  end
endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: scans the captured frame buffer, upscales each pixel to a square block
// and drives registered VGA pins three clocks behind the raster counters.
module vga_frame_reader #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP = vga_pkg::V_BP,
  parameter int IMG_W = vga_pkg::IMG_W,
  parameter int IMG_H = vga_pkg::IMG_H,
  parameter int SCALE_SHIFT = vga_pkg::SCALE_SHIFT,
  parameter int ADDR_W = vga_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [2:0]        vga_r,
  output logic [2:0]        vga_g,
  output logic [1:0]        vga_b,
  output logic              frame_start
);
  import vga_pkg::CNT_W;
  import vga_pkg::rgb332_t;
  localparam logic [CNT_W-1:0] GRP = CNT_W'((1 << SCALE_SHIFT) - 1);
  logic [CNT_W-1:0] h, v;
  logic hs, vs, img, fs, h_wrap, v_wrap;
  logic [ADDR_W-1:0] row_base_q, rd_addr_q;
  logic [1:0] img_q, hs_q, vs_q, fs_q;
  rgb332_t px;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE_SHIFT(SCALE_SHIFT)
  ) u_timing (
    .clk(clk), .rst(rst), .h_o(h), .v_o(v), .hs_o(hs), .vs_o(vs),
    .img_o(img), .fs_o(fs), .h_wrap_o(h_wrap), .v_wrap_o(v_wrap)
  );
  assign rd_addr = rd_addr_q;
  assign px = rgb332_t'(rd_data);
  // bit 0 of each delay pair is the S1 copy, bit 1 the S2 copy aligned with rd_data
  always_ff @(posedge clk) begin
    if (rst) begin
      row_base_q <= '0;
      rd_addr_q <= '0;
      img_q <= '0;
      hs_q <= '1;
      vs_q <= '1;
      fs_q <= '0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
      frame_start <= 1'b0;
    end else begin
      if (h_wrap) row_base_q <= v_wrap ? '0 : (v & GRP) == GRP ? row_base_q + ADDR_W'(IMG_W) : row_base_q;
      rd_addr_q <= img ? row_base_q + ADDR_W'(h >> SCALE_SHIFT) : '0;
      img_q <= {img_q[0], img};
      hs_q <= {hs_q[0], hs};
      vs_q <= {vs_q[0], vs};
      fs_q <= {fs_q[0], fs};
      vga_hsync <= hs_q[1];
      vga_vsync <= vs_q[1];
      vga_r <= img_q[1] ? px.r : '0;
      vga_g <= img_q[1] ? px.g : '0;
      vga_b <= img_q[1] ? px.b : '0;
      frame_start <= fs_q[1];
    end
  end
endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: directed checks on a reduced raster (96x32 total, 64x24 active,
// 12x5 stored image at 4x) so several whole frames fit in a short run.
module tb_vga_frame_reader;
  localparam int HT = 96, VT = 32, FRAME = HT * VT;
  localparam int HS_FALL = 72, VS_FALL = 26 * HT;
  logic clk = 1'b0, rst = 1'b1;
  logic [14:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic hs, vs, fs;
  logic [2:0] r, g;
  logic [1:0] b;
  int errors = 0, checks = 0, p = 0;
  always #20 clk = ~clk;
  always @(posedge clk) rd_data <= rd_addr[7:0];
  vga_frame_reader #(
    .H_ACTIVE(64), .H_FP(8), .H_SYNC(16), .H_BP(8),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .IMG_W(12), .IMG_H(5), .SCALE_SHIFT(2), .ADDR_W(15)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .vga_hsync(hs), .vga_vsync(vs), .vga_r(r), .vga_g(g), .vga_b(b), .frame_start(fs)
  );
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    p += n;
  endtask
  task automatic goto(input int t);
    if (t > p) step(t - p);
  endtask
  task automatic sync_frame();
    int n = 0;
    @(negedge clk);
    while (fs !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fs !== 1'b1) begin
      errors++;
      $display("FAIL sync_frame: frame_start=%b after %0d clk, required 1", fs, n);
    end
    p = 0;
  endtask
  task automatic check_release(input string name);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (fs !== (k == 3)) begin
        errors++;
        $display("FAIL %s frame_start at release+%0d: got %b, required %b", name, k, fs, k == 3);
      end
    end
    p = 0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({hs, vs, r, g, b, fs} !== {2'b11, 9'b0}) begin
        errors++;
        $display("FAIL reset_pins: hs=%b vs=%b rgb=%h fs=%b, required hs=1 vs=1 rgb=00 fs=0", hs, vs, {r, g, b}, fs);
      end
    end
    checks++;
    if (rd_addr !== 15'd0) begin
      errors++;
      $display("FAIL reset_addr: got %0d, required 0", rd_addr);
    end
    rst = 1'b0;
    check_release("cold_start");
  endtask
  task automatic test_frame_period();
    int n = 1;
    step(1);
    checks++;
    if (fs !== 1'b0) begin
      errors++;
      $display("FAIL fs_width: frame_start=%b one clk after pulse, required 0", fs);
    end
    while (fs !== 1'b1 && n < 2 * FRAME) begin
      step(1);
      n++;
    end
    checks++;
    if (n != FRAME) begin
      errors++;
      $display("FAIL fs_period: got %0d clk, required %0d", n, FRAME);
    end
    p = 0;
  endtask
  task automatic test_hsync(input string name);
    int pts[6] = '{HS_FALL - 1, HS_FALL, HS_FALL + 15, HS_FALL + 16, HT + HS_FALL - 1, HT + HS_FALL};
    logic exp_hs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      goto(pts[i]);
      checks++;
      if (hs !== exp_hs[i]) begin
        errors++;
        $display("FAIL %s hsync at %0d after frame_start: got %b, required %b", name, pts[i], hs, exp_hs[i]);
      end
    end
  endtask
  task automatic test_vsync();
    int pts[4] = '{VS_FALL - 1, VS_FALL, VS_FALL + 2 * HT - 1, VS_FALL + 2 * HT};
    logic exp_vs[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      goto(pts[i]);
      checks++;
      if (vs !== exp_vs[i]) begin
        errors++;
        $display("FAIL vsync at %0d after frame_start: got %b, required %b", pts[i], vs, exp_vs[i]);
      end
    end
  endtask
  task automatic test_addr();
    int lines[5] = '{0, 4, 19, 20, 24};
    int exp_a;
    sync_frame();
    foreach (lines[i]) begin
      for (int x = (lines[i] == 0 ? 2 : 0); x < HT; x++) begin
        exp_a = (lines[i] < 20 && x < 48) ? (lines[i] / 4) * 12 + x / 4 : 0;
        goto(lines[i] * HT + x - 2);
        checks++;
        if (rd_addr !== 15'(exp_a)) begin
          errors++;
          $display("FAIL addr (x=%0d,v=%0d): got %0d, required %0d", x, lines[i], rd_addr, exp_a);
        end
      end
    end
  endtask
  task automatic test_pixels(input string name);
    int xs[8] = '{4, 8, 48, 70, 5, 47, 0, 10};
    int ys[8] = '{0, 0, 0, 0, 4, 19, 20, 26};
    logic [7:0] exp_px[8] = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h0D, 8'h3B, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      goto(ys[i] * HT + xs[i]);
      checks++;
      if ({r, g, b} !== exp_px[i]) begin
        errors++;
        $display("FAIL %s pixel (%0d,%0d): got %h, required %h", name, xs[i], ys[i], {r, g, b}, exp_px[i]);
      end
      if (i == 1) begin
        checks++;
        if (r !== 3'd0 || g !== 3'd0 || b !== 2'd2) begin
          errors++;
          $display("FAIL %s split (8,0): got r=%0d g=%0d b=%0d, required r=0 g=0 b=2", name, r, g, b);
        end
      end
      if (i == 5) begin
        checks++;
        if (r !== 3'd1 || g !== 3'd6 || b !== 2'd3) begin
          errors++;
          $display("FAIL %s split (47,19): got r=%0d g=%0d b=%0d, required r=1 g=6 b=3", name, r, g, b);
        end
      end
    end
  endtask
  task automatic test_mid_reset();
    sync_frame();
    goto(10 * HT + 40);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({hs, vs, r, g, b, fs} !== {2'b11, 9'b0}) begin
      errors++;
      $display("FAIL mid_reset_pins: hs=%b vs=%b rgb=%h fs=%b, required hs=1 vs=1 rgb=00 fs=0", hs, vs, {r, g, b}, fs);
    end
    rst = 1'b0;
    check_release("mid_reset");
    goto(4 * HT + 6);
    checks++;
    if (rd_addr !== 15'd14) begin
      errors++;
      $display("FAIL mid_reset addr (8,4): got %0d, required 14", rd_addr);
    end
    p = 0;
    sync_frame();
  endtask
  initial begin
    test_reset();
    test_frame_period();
    test_hsync("cold");
    test_vsync();
    test_addr();
    sync_frame();
    test_pixels("cold");
    test_mid_reset();
    test_frame_period();
    test_hsync("after_reset");
    sync_frame();
    test_pixels("after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
